axi_master_isolate: RTL and testbench
=====================================

// Module: axi_master_isolate
// PURPOSE
//  Protocol-safe successor to the testbench AXI master hookup: sits between the core AXI req/resp
//  structs and the memory-side AXI port. On isolate request it stops accepting new AW/AR, drains
//  every outstanding burst, then holds the downstream port idle. It never drops a beat mid-burst.
//  It also bounds outstanding transactions per direction.
// PARAMETERS
//  MaxRdTxn  default 8        max outstanding read bursts (AR accepted, R-last not yet seen)
//  MaxWrTxn  default 8        max outstanding write bursts (AW accepted, B not yet seen)
//  req_t     ariane_axi::req_t   AXI request struct type
//  resp_t    ariane_axi::resp_t  AXI response struct type
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       synchronous reset, active-high
//  isolate_i    in   1       level request: drain, then isolate
//  isolated_o   in/out: out 1  high only in ISOLATED state
//  slv_req_i    in   req_t   request from core
//  slv_resp_o   out  resp_t  response to core
//  mst_req_o    out  req_t   request to memory
//  mst_resp_i   in   resp_t  response from memory
//  rd_cnt_o     out  $clog2(MaxRdTxn+1)  outstanding read bursts
//  wr_cnt_o     out  $clog2(MaxWrTxn+1)  outstanding write bursts
// BEHAVIOUR
//  Reset: state ACTIVE, rd_cnt/wr_cnt/w_pend = 0, isolated_o = 0. Registers clear on the first
//   rising edge with rst_i = 1. A reset during DRAINING abandons the counts. The bench must reset
//   the memory model together with this block.
//  Counters (saturating, no wrap):
//   rd_cnt +1 on mst AR handshake, -1 on R handshake with r.last.
//   wr_cnt +1 on AW handshake, -1 on B handshake.
//   w_pend +1 on AW handshake, -1 on W handshake with w.last. w_pend has the MaxWrTxn range.
//   On the same cycle as an inc and a dec, the counter is unchanged.
//  Gating, combinational with no added latency in ACTIVE:
//   AW passes when state==ACTIVE && wr_cnt<MaxWrTxn. Otherwise mst aw_valid=0 and slv aw_ready=0.
//   AR passes when state==ACTIVE && rd_cnt<MaxRdTxn. Otherwise it is blocked the same way.
//   W: ACTIVE passes W unconditionally (W-before-AW is legal). In DRAINING it passes only while
//    w_pend>0. In ISOLATED it is blocked.
//   R and B always pass in ACTIVE and DRAINING.
//   ISOLATED: every mst valid/ready = 0, every slv valid/ready = 0, and all mst payload = '0.
//  Blocking never removes a valid already presented downstream:
//   A sticky aw_hold/ar_hold flag is set when mst valid is high without ready.
//   While the flag is set, the channel stays forwarded until its handshake, even after the
//    state leaves ACTIVE.
//   Those handshakes still count.
//  FSM:
//   ACTIVE   -> DRAINING when isolate_i=1.
//   DRAINING -> ISOLATED when all of these hold: rd_cnt==0, wr_cnt==0, w_pend==0, no hold
//    flag, and isolate_i=1.
//   DRAINING -> ACTIVE when isolate_i=0 (abort; counts kept).
//   ISOLATED -> ACTIVE when isolate_i=0, one cycle later.
//  isolated_o is registered from the state.
//  A count that is already idle goes ACTIVE -> DRAINING -> ISOLATED in 2 cycles.
//  Underflow (response with count 0) is a protocol error: an assertion fires and the count holds 0.
// STRUCTURE
//  Shared package (ariane_axi or tb pkg): isolate_state_e {ACTIVE, DRAINING, ISOLATED}.
//  One natural sub-module: axi_txn_counter (inc, dec, max; up/down saturating with full/empty).
//   It is instantiated 3x, for rd, wr and w_pend.
//  Top level holds the FSM, the hold flags and the channel muxing.
// TESTING
//  1 Idle, isolate_i=1 at cycle 10 -> isolated_o=1 at cycle 12; all mst valids 0 afterwards.
//  2 AR len=7 accepted, isolate_i=1 after beat 2 -> all 8 R beats reach the core.
//     isolated_o rises 1 cycle after R-last; no new AR is forwarded.
//  3 AW accepted, isolate_i=1, then 4 W beats and B -> W forwarded (w_pend=1).
//     isolated_o rises after B; an AW presented during the drain is stalled, aw_ready=0.
//  4 MaxRdTxn=2: issue 3 ARs without R -> 3rd AR stalled with ar_ready=0 until the first R-last.
//  5 isolate_i pulsed 1 for 3 cycles during an outstanding write -> returns to ACTIVE.
//     wr_cnt preserved and B decrements it to 0.
//  6 Memory holds aw_ready=0 while aw_valid=1, then isolate_i=1 -> aw_valid stays 1 until ready.
//     wr_cnt=1, then drain completes normally.

Source files
------------

// File: rtl/axi_master_isolate_pkg.sv
// Shared types for the AXI master isolation slice.
// Carries the simplified AXI request/response structs and the FSM state enum.
package axi_master_isolate_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 64;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAINING,
    ISOLATED
  } isolate_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
  } ax_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    b_t   b;
    logic r_valid;
    r_t   r;
  } resp_t;

endpackage

// File: rtl/axi_master_isolate_if.sv
// AXI request/response bundle for one side of the isolator.
// master drives requests, slave drives responses.
interface axi_master_isolate_if;
  import axi_master_isolate_pkg::*;

  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/axi_master_isolate_txn_counter.sv
// Up/down saturating outstanding-transaction counter.
// Simultaneous inc and dec leave the count unchanged.
module axi_txn_counter #(
  parameter int unsigned Max          = 8,
  parameter bit          ChkUnderflow = 1'b1,
  localparam int unsigned W           = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] cnt_q;

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == W'(Max));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A response arriving with nothing outstanding is a protocol error.
  underflow_chk: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(ChkUnderflow && dec_i && !inc_i && empty_o)
  );

endmodule

// File: rtl/axi_master_isolate.sv
// Drains outstanding AXI bursts on request, then holds the memory port idle.
// Also caps outstanding read and write bursts.
module axi_master_isolate
  import axi_master_isolate_pkg::*;
#(
  parameter int unsigned MaxRdTxn = 8,
  parameter int unsigned MaxWrTxn = 8,
  localparam int unsigned RdW     = $clog2(MaxRdTxn + 1),
  localparam int unsigned WrW     = $clog2(MaxWrTxn + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   isolate_i,
  output logic                   isolated_o,
  axi_master_isolate_if.slave    slv,
  axi_master_isolate_if.master   mst,
  output logic [RdW-1:0]         rd_cnt_o,
  output logic [WrW-1:0]         wr_cnt_o
);

  isolate_state_e state_q, state_d;
  logic aw_hold_q, ar_hold_q, isolated_q;
  logic rd_full, rd_empty, wr_full, wr_empty;
  logic wp_full, wp_empty;
  logic [WrW-1:0] wp_cnt;
  logic aw_pass, ar_pass, w_pass, rb_pass;
  logic aw_hs, ar_hs, w_last_hs, r_last_hs, b_hs;

  // Hold flags keep a presented valid forwarded regardless of state.
  assign aw_pass = ((state_q == ACTIVE) && !wr_full && !wp_full)
                 || aw_hold_q;
  assign ar_pass = ((state_q == ACTIVE) && !rd_full) || ar_hold_q;
  assign w_pass  = (state_q == ACTIVE)
                 || ((state_q == DRAINING) && (wp_cnt != '0));
  assign rb_pass = (state_q != ISOLATED);

  always_comb begin
    mst.req  = slv.req;
    slv.resp = mst.resp;
    mst.req.aw_valid  = slv.req.aw_valid & aw_pass;
    mst.req.ar_valid  = slv.req.ar_valid & ar_pass;
    mst.req.w_valid   = slv.req.w_valid & w_pass;
    mst.req.b_ready   = slv.req.b_ready & rb_pass;
    mst.req.r_ready   = slv.req.r_ready & rb_pass;
    slv.resp.aw_ready = mst.resp.aw_ready & aw_pass;
    slv.resp.ar_ready = mst.resp.ar_ready & ar_pass;
    slv.resp.w_ready  = mst.resp.w_ready & w_pass;
    slv.resp.b_valid  = mst.resp.b_valid & rb_pass;
    slv.resp.r_valid  = mst.resp.r_valid & rb_pass;
    if (state_q == ISOLATED) begin
      mst.req  = '0;
      slv.resp = '0;
    end
  end

  assign aw_hs     = mst.req.aw_valid & mst.resp.aw_ready;
  assign ar_hs     = mst.req.ar_valid & mst.resp.ar_ready;
  assign w_last_hs = mst.req.w_valid & mst.resp.w_ready
                   & mst.req.w.last;
  assign r_last_hs = mst.resp.r_valid & mst.req.r_ready
                   & mst.resp.r.last;
  assign b_hs      = mst.resp.b_valid & mst.req.b_ready;

  axi_txn_counter #(.Max(MaxRdTxn)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .cnt_o   (rd_cnt_o),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  axi_txn_counter #(.Max(MaxWrTxn)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .cnt_o   (wr_cnt_o),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  // W may legally lead its AW, so a zero-count decrement is not an error here.
  axi_txn_counter #(.Max(MaxWrTxn), .ChkUnderflow(1'b0)) u_wp_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (w_last_hs),
    .cnt_o   (wp_cnt),
    .full_o  (wp_full),
    .empty_o (wp_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE: begin
        if (isolate_i) state_d = DRAINING;
      end
      DRAINING: begin
        if (!isolate_i) begin
          state_d = ACTIVE;
        end else if (rd_empty && wr_empty && wp_empty
                     && !aw_hold_q && !ar_hold_q) begin
          state_d = ISOLATED;
        end
      end
      ISOLATED: begin
        if (!isolate_i) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      aw_hold_q  <= 1'b0;
      ar_hold_q  <= 1'b0;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_hold_q  <= mst.req.aw_valid & ~mst.resp.aw_ready;
      ar_hold_q  <= mst.req.ar_valid & ~mst.resp.ar_ready;
      isolated_q <= (state_d == ISOLATED);
    end
  end

  assign isolated_o = isolated_q;

endmodule

// File: tb/tb_axi_master_isolate.sv
// Directed bench for axi_master_isolate with MaxRdTxn = MaxWrTxn = 2.
// The bench plays both the core and the memory side.
module tb_axi_master_isolate;
  import axi_master_isolate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       isolate;
  logic       isolated;
  logic [1:0] rd_cnt;
  logic [1:0] wr_cnt;
  int         npass = 0;
  int         nfail = 0;
  int         ntotal = 0;

  always #5 clk = ~clk;

  axi_master_isolate_if slv ();
  axi_master_isolate_if mst ();

  axi_master_isolate #(
    .MaxRdTxn (2),
    .MaxWrTxn (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .isolate_i  (isolate),
    .isolated_o (isolated),
    .slv        (slv),
    .mst        (mst),
    .rd_cnt_o   (rd_cnt),
    .wr_cnt_o   (wr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    slv.req  = '0;
    mst.resp = '0;
    rst      = 1'b1;
    isolate  = 1'b0;
    tick();
    tick();
    chk("rst_isolated", isolated, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: idle isolation takes two edges
    isolate = 1'b1;
    #1;
    chk("t1_pre", isolated, 0);
    tick();
    chk("t1_drain", isolated, 0);
    tick();
    chk("t1_on", isolated, 1);
    slv.req.ar_valid  = 1'b1;
    slv.req.ar.addr   = 32'h40;
    slv.req.aw_valid  = 1'b1;
    slv.req.w_valid   = 1'b1;
    mst.resp.ar_ready = 1'b1;
    mst.resp.aw_ready = 1'b1;
    mst.resp.w_ready  = 1'b1;
    mst.resp.r_valid  = 1'b1;
    #1;
    chk("t1_ar_valid", mst.req.ar_valid, 0);
    chk("t1_aw_valid", mst.req.aw_valid, 0);
    chk("t1_w_valid", mst.req.w_valid, 0);
    chk("t1_ar_addr", mst.req.ar.addr, 0);
    chk("t1_ar_ready", slv.resp.ar_ready, 0);
    chk("t1_r_valid", slv.resp.r_valid, 0);
    tick();
    chk("t1_rd_cnt", rd_cnt, 0);
    chk("t1_wr_cnt", wr_cnt, 0);
    slv.req  = '0;
    mst.resp = '0;
    isolate  = 1'b0;
    tick();
    chk("t1_off", isolated, 0);

    // 2: read burst of 8 drains fully
    slv.req.ar_valid  = 1'b1;
    slv.req.ar.addr   = 32'h100;
    slv.req.ar.len    = 8'd7;
    slv.req.r_ready   = 1'b1;
    mst.resp.ar_ready = 1'b1;
    #1;
    chk("t2_ar_fwd", mst.req.ar_valid, 1);
    chk("t2_ar_rdy", slv.resp.ar_ready, 1);
    tick();
    chk("t2_rd_cnt1", rd_cnt, 1);
    slv.req.ar_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) isolate = 1'b1;
      if (i >= 4) begin
        slv.req.ar_valid = 1'b1;
        slv.req.ar.addr  = 32'h200;
      end
      mst.resp.r_valid = 1'b1;
      mst.resp.r.data  = 64'hA0 + 64'(i);
      mst.resp.r.last  = (i == 7);
      #1;
      chk("t2_r_valid", slv.resp.r_valid, 1);
      chk("t2_r_data", slv.resp.r.data, 64'hA0 + 64'(i));
      if (i >= 4) chk("t2_ar_blocked", mst.req.ar_valid, 0);
      tick();
    end
    mst.resp.r_valid = 1'b0;
    mst.resp.r.last  = 1'b0;
    #1;
    chk("t2_rd_cnt0", rd_cnt, 0);
    chk("t2_not_yet", isolated, 0);
    chk("t2_ar_rdy0", slv.resp.ar_ready, 0);
    tick();
    chk("t2_isolated", isolated, 1);
    slv.req  = '0;
    mst.resp = '0;
    isolate  = 1'b0;
    tick();
    chk("t2_off", isolated, 0);

    // 3: write drain forwards W while w_pend is nonzero
    slv.req.aw_valid  = 1'b1;
    slv.req.aw.addr   = 32'h300;
    slv.req.aw.len    = 8'd3;
    mst.resp.aw_ready = 1'b1;
    #1;
    chk("t3_aw_fwd", mst.req.aw_valid, 1);
    tick();
    chk("t3_wr_cnt1", wr_cnt, 1);
    slv.req.aw_valid = 1'b0;
    isolate = 1'b1;
    tick();
    slv.req.aw_valid = 1'b1;
    slv.req.aw.addr  = 32'h400;
    slv.req.w_valid  = 1'b1;
    mst.resp.w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv.req.w.data = 64'(i) + 64'h30;
      slv.req.w.last = (i == 3);
      #1;
      chk("t3_w_fwd", mst.req.w_valid, 1);
      chk("t3_w_data", mst.req.w.data, 64'(i) + 64'h30);
      chk("t3_aw_stall", mst.req.aw_valid, 0);
      chk("t3_aw_rdy0", slv.resp.aw_ready, 0);
      tick();
    end
    slv.req.w.last = 1'b0;
    #1;
    chk("t3_w_block", mst.req.w_valid, 0);
    chk("t3_w_rdy0", slv.resp.w_ready, 0);
    slv.req.w_valid  = 1'b0;
    mst.resp.b_valid = 1'b1;
    slv.req.b_ready  = 1'b1;
    #1;
    chk("t3_b_fwd", slv.resp.b_valid, 1);
    chk("t3_b_rdy", mst.req.b_ready, 1);
    tick();
    chk("t3_wr_cnt0", wr_cnt, 0);
    chk("t3_not_yet", isolated, 0);
    mst.resp.b_valid = 1'b0;
    tick();
    chk("t3_isolated", isolated, 1);
    chk("t3_aw_iso", mst.req.aw_valid, 0);
    slv.req  = '0;
    mst.resp = '0;
    isolate  = 1'b0;
    tick();

    // 4: read limit of 2 stalls the third AR
    slv.req.ar_valid  = 1'b1;
    slv.req.ar.id     = 4'd1;
    slv.req.r_ready   = 1'b1;
    mst.resp.ar_ready = 1'b1;
    tick();
    chk("t4_rd1", rd_cnt, 1);
    slv.req.ar.id = 4'd2;
    #1;
    chk("t4_ar2_fwd", mst.req.ar_valid, 1);
    tick();
    chk("t4_rd2", rd_cnt, 2);
    slv.req.ar.id = 4'd3;
    #1;
    chk("t4_ar3_stall", mst.req.ar_valid, 0);
    chk("t4_ar3_rdy0", slv.resp.ar_ready, 0);
    tick();
    chk("t4_rd2_hold", rd_cnt, 2);
    mst.resp.r_valid = 1'b1;
    mst.resp.r.last  = 1'b1;
    #1;
    chk("t4_ar3_still", mst.req.ar_valid, 0);
    tick();
    mst.resp.r_valid = 1'b0;
    #1;
    chk("t4_rd_dec", rd_cnt, 1);
    chk("t4_ar3_fwd", mst.req.ar_valid, 1);
    chk("t4_ar3_rdy", slv.resp.ar_ready, 1);
    tick();
    chk("t4_rd2_again", rd_cnt, 2);
    slv.req.ar_valid = 1'b0;
    mst.resp.r_valid = 1'b1;
    tick();
    tick();
    mst.resp.r_valid = 1'b0;
    #1;
    chk("t4_rd0", rd_cnt, 0);
    slv.req  = '0;
    mst.resp = '0;

    // 5: isolate pulse aborts the drain, count survives
    slv.req.aw_valid  = 1'b1;
    mst.resp.aw_ready = 1'b1;
    tick();
    slv.req.aw_valid  = 1'b0;
    mst.resp.aw_ready = 1'b0;
    slv.req.w_valid   = 1'b1;
    slv.req.w.last    = 1'b1;
    mst.resp.w_ready  = 1'b1;
    tick();
    slv.req.w_valid  = 1'b0;
    slv.req.w.last   = 1'b0;
    mst.resp.w_ready = 1'b0;
    isolate = 1'b1;
    tick();
    tick();
    tick();
    slv.req.w_valid = 1'b1;
    #1;
    chk("t5_w_block", mst.req.w_valid, 0);
    chk("t5_not_iso", isolated, 0);
    chk("t5_wr1", wr_cnt, 1);
    isolate = 1'b0;
    tick();
    chk("t5_active_w", mst.req.w_valid, 1);
    chk("t5_wr_kept", wr_cnt, 1);
    slv.req.w_valid  = 1'b0;
    mst.resp.b_valid = 1'b1;
    slv.req.b_ready  = 1'b1;
    tick();
    mst.resp.b_valid = 1'b0;
    #1;
    chk("t5_wr0", wr_cnt, 0);
    slv.req  = '0;
    mst.resp = '0;

    // 6: presented AW survives the transition into DRAINING
    slv.req.aw_valid = 1'b1;
    slv.req.aw.addr  = 32'h600;
    #1;
    chk("t6_aw_fwd", mst.req.aw_valid, 1);
    tick();
    isolate = 1'b1;
    tick();
    chk("t6_aw_hold", mst.req.aw_valid, 1);
    chk("t6_aw_rdy0", slv.resp.aw_ready, 0);
    chk("t6_aw_addr", mst.req.aw.addr, 32'h600);
    tick();
    chk("t6_aw_hold2", mst.req.aw_valid, 1);
    chk("t6_not_iso", isolated, 0);
    mst.resp.aw_ready = 1'b1;
    #1;
    chk("t6_aw_rdy", slv.resp.aw_ready, 1);
    tick();
    slv.req.aw_valid  = 1'b0;
    mst.resp.aw_ready = 1'b0;
    #1;
    chk("t6_wr1", wr_cnt, 1);
    slv.req.w_valid  = 1'b1;
    slv.req.w.last   = 1'b1;
    mst.resp.w_ready = 1'b1;
    #1;
    chk("t6_w_fwd", mst.req.w_valid, 1);
    tick();
    slv.req.w_valid  = 1'b0;
    mst.resp.b_valid = 1'b1;
    slv.req.b_ready  = 1'b1;
    tick();
    mst.resp.b_valid = 1'b0;
    #1;
    chk("t6_wr0", wr_cnt, 0);
    chk("t6_not_yet", isolated, 0);
    tick();
    chk("t6_isolated", isolated, 1);
    slv.req  = '0;
    mst.resp = '0;
    isolate  = 1'b0;
    tick();
    chk("t6_off", isolated, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
